// File: rtl/mmc3_irq_unit.sv
// MMC3 scanline IRQ: filtered PPU A12 edge counter with reload/enable regs.
// Define MMC3_IRQ_ALT_EN for the older-revision IRQ trigger rule.
module mmc3_irq_unit (
    input  logic       m2,
    input  logic       rst_n,
    input  logic       reg_wr,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_data,
    input  logic       ppu_a12,
    output logic       irq,
    output logic [7:0] irq_counter
);

    logic       a12_m;
    logic       a12_s;
    logic       a12_q;
    logic [1:0] low_cnt;
    logic       clk_ev;

    logic [7:0] counter;
    logic [7:0] reload_val;
    logic       reload_flag;
    logic       irq_en;
    logic       irq_pending;

    logic       wr_latch;
    logic       wr_reload;
    logic       wr_dis;
    logic       wr_en;

    logic [7:0] rv_eff;
    logic [7:0] cnt_nxt;
    logic       flag_nxt;
    logic       do_reload;
    logic       ev_fire;
    logic       en_nxt;
    logic       pend_nxt;

    always_comb begin
        wr_latch  = 1'b0;
        wr_reload = 1'b0;
        wr_dis    = 1'b0;
        wr_en     = 1'b0;
        if (reg_wr) begin
            unique case (reg_sel)
                2'b00: wr_latch  = 1'b1;
                2'b01: wr_reload = 1'b1;
                2'b10: wr_dis    = 1'b1;
                2'b11: wr_en     = 1'b1;
            endcase
        end
    end

    // A rise only counts after three consecutive low samples.
    assign clk_ev = a12_s & ~a12_q & (low_cnt == 2'd3);

    always_comb begin
        rv_eff    = wr_latch ? reg_data : reload_val;
        do_reload = (counter == 8'd0) | reload_flag;
        cnt_nxt   = counter;
        flag_nxt  = reload_flag;
        ev_fire   = 1'b0;
        if (wr_reload) begin
            cnt_nxt  = 8'd0;
            flag_nxt = 1'b1;
        end else if (clk_ev) begin
            if (do_reload) begin
                cnt_nxt  = rv_eff;
                flag_nxt = 1'b0;
            end else begin
                cnt_nxt = counter - 8'd1;
            end
`ifdef MMC3_IRQ_ALT_EN
            ev_fire = do_reload
                ? (reload_flag & (rv_eff == 8'd0))
                : (counter == 8'd1);
`else
            ev_fire = (cnt_nxt == 8'd0);
`endif
        end
    end

    always_comb begin
        en_nxt   = irq_en;
        pend_nxt = irq_pending | (ev_fire & irq_en);
        if (wr_en) en_nxt = 1'b1;
        if (wr_dis) begin
            en_nxt   = 1'b0;
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            a12_m   <= 1'b0;
            a12_s   <= 1'b0;
            a12_q   <= 1'b0;
            low_cnt <= 2'd0;
        end else begin
            a12_m <= ppu_a12;
            a12_s <= a12_m;
            a12_q <= a12_s;
            if (a12_s)
                low_cnt <= 2'd0;
            else if (low_cnt != 2'd3)
                low_cnt <= low_cnt + 2'd1;
        end
    end

    always_ff @(posedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            counter     <= 8'd0;
            reload_val  <= 8'd0;
            reload_flag <= 1'b0;
            irq_en      <= 1'b0;
            irq_pending <= 1'b0;
            irq         <= 1'b1;
        end else begin
            counter     <= cnt_nxt;
            reload_val  <= rv_eff;
            reload_flag <= flag_nxt;
            irq_en      <= en_nxt;
            irq_pending <= pend_nxt;
            irq         <= ~pend_nxt;
        end
    end

    assign irq_counter = counter;

endmodule

// File: tb/tb_mmc3_irq_unit.sv
// Bench for mmc3_irq_unit: directed scenarios then random traffic,
// all checked against a rule-level reference model.
module tb_mmc3_irq_unit;

    logic       m2;
    logic       rst_n;
    logic       reg_wr;
    logic [1:0] reg_sel;
    logic [7:0] reg_data;
    logic       a12;
    logic       irq;
    logic [7:0] irq_counter;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_pq[$];
    int m_low;
    int m_cnt;
    int m_rv;
    bit m_flag;
    bit m_en;
    bit m_pend;

    mmc3_irq_unit dut (
        .m2          (m2),
        .rst_n       (rst_n),
        .reg_wr      (reg_wr),
        .reg_sel     (reg_sel),
        .reg_data    (reg_data),
        .ppu_a12     (a12),
        .irq         (irq),
        .irq_counter (irq_counter)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pq   = {0, 0};
        m_low  = 0;
        m_cnt  = 0;
        m_rv   = 0;
        m_flag = 0;
        m_en   = 0;
        m_pend = 0;
    endtask

    task automatic model_step(input bit w, input int s,
                              input int d, input bit p);
        int  a;
        bit  ev;
        bit  rl;
        bit  pflag;
        bit  fire;
        a = m_pq.pop_front();
        m_pq.push_back(int'(p));
        ev = (a == 1) && (m_low >= 3);
        m_low = (a == 1) ? 0 : m_low + 1;
        if (w && s == 0) m_rv = d;
        fire = 0;
        if (w && s == 1) begin
            m_cnt  = 0;
            m_flag = 1;
        end else if (ev) begin
            rl    = (m_cnt == 0) || m_flag;
            pflag = m_flag;
            if (rl) begin
                m_cnt  = m_rv;
                m_flag = 0;
            end else begin
                m_cnt = m_cnt - 1;
            end
`ifdef MMC3_IRQ_ALT_EN
            fire = (!rl && m_cnt == 0) || (pflag && m_rv == 0);
`else
            fire = (m_cnt == 0);
`endif
        end
        if (fire && m_en) m_pend = 1;
        if (w && s == 2) begin
            m_en   = 0;
            m_pend = 0;
        end
        if (w && s == 3) m_en = 1;
    endtask

    task automatic cyc(input logic w, input logic [1:0] s,
                       input logic [7:0] d, input logic p);
        @(negedge m2);
        reg_wr   = w;
        reg_sel  = s;
        reg_data = d;
        a12      = p;
        @(posedge m2);
        model_step(w, int'(s), int'(d), p);
        #1;
        check("irq", {7'd0, irq}, {7'd0, ~m_pend});
        check("cnt", irq_counter, m_cnt[7:0]);
    endtask

    task automatic idle(input logic p);
        cyc(1'b0, 2'd0, 8'd0, p);
    endtask

    // lows low cycles, then three high cycles; the event lands on the
    // last one, where the optional register write is also issued
    task automatic pulse(input int lows,
                         input logic w = 1'b0,
                         input logic [1:0] s = 2'd0,
                         input logic [7:0] d = 8'd0);
        for (int i = 0; i < lows; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        cyc(w, s, d, 1'b1);
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        cyc(1'b1, s, d, a12);
    endtask

    initial begin
        int run;
        bit p;
        rst_n    = 1'b0;
        reg_wr   = 1'b0;
        reg_sel  = 2'd0;
        reg_data = 8'd0;
        a12      = 1'b0;
        model_reset();
        repeat (3) @(posedge m2);
        #1;
        check("rst_irq", {7'd0, irq}, 8'd1);
        check("rst_cnt", irq_counter, 8'd0);
        rst_n = 1'b1;
        idle(1'b0);
        check("post_rst_irq", {7'd0, irq}, 8'd1);
        check("post_rst_cnt", irq_counter, 8'd0);

        // latch 3, reload, enable, four filtered rises
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd0);
        wr(2'd3, 8'd0);
        pulse(4);
        check("seq_3", irq_counter, 8'd3);
        pulse(4);
        check("seq_2", irq_counter, 8'd2);
        pulse(4);
        check("seq_1", irq_counter, 8'd1);
        for (int i = 0; i < 4; i++) idle(1'b0);
        idle(1'b1);
        check("lat_1", {7'd0, irq}, 8'd1);
        idle(1'b1);
        check("lat_2", {7'd0, irq}, 8'd1);
        idle(1'b1);
        check("lat_3", {7'd0, irq}, 8'd0);
        check("seq_0", irq_counter, 8'd0);

        // short low run is filtered
        pulse(2);
        check("filt_cnt", irq_counter, 8'd0);

        // disable clears irq, enable leaves it clear
        wr(2'd2, 8'd0);
        check("dis_irq", {7'd0, irq}, 8'd1);
        wr(2'd3, 8'd0);
        idle(1'b1);
        idle(1'b1);
        check("en_irq", {7'd0, irq}, 8'd1);

        // reload write collides with an event at counter 5
        wr(2'd0, 8'd7);
        wr(2'd1, 8'd0);
        pulse(4);
        pulse(4);
        pulse(4);
        check("pre_col", irq_counter, 8'd5);
        pulse(4, 1'b1, 2'd1, 8'd0);
        check("col_cnt", irq_counter, 8'd0);
        pulse(4);
        check("col_next", irq_counter, 8'd7);

        // latch write in the same cycle as a reloading event
        wr(2'd1, 8'd0);
        pulse(4, 1'b1, 2'd0, 8'd9);
        check("latch_col", irq_counter, 8'd9);

        // disable wins over a simultaneous irq set
        wr(2'd0, 8'd1);
        wr(2'd1, 8'd0);
        pulse(4);
        check("dw_pre", irq_counter, 8'd1);
        pulse(4, 1'b1, 2'd2, 8'd0);
        check("dw_cnt", irq_counter, 8'd0);
        check("dw_irq", {7'd0, irq}, 8'd1);

        // reload value 0
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd0);
        wr(2'd3, 8'd0);
        pulse(4);
        check("z1_cnt", irq_counter, 8'd0);
        check("z1_irq", {7'd0, irq}, 8'd0);
        wr(2'd2, 8'd0);
        wr(2'd3, 8'd0);
        pulse(4);
        check("z2_cnt", irq_counter, 8'd0);
`ifdef MMC3_IRQ_ALT_EN
        check("z2_irq", {7'd0, irq}, 8'd1);
`else
        check("z2_irq", {7'd0, irq}, 8'd0);
`endif

        // reset while irq is asserted
        wr(2'd0, 8'd2);
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd0);
        wr(2'd3, 8'd0);
        pulse(4);
        pulse(4);
        pulse(4);
        check("pr_irq", {7'd0, irq}, 8'd0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ar_irq", {7'd0, irq}, 8'd1);
        check("ar_cnt", irq_counter, 8'd0);
        repeat (2) @(posedge m2);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        check("ar_rel_irq", {7'd0, irq}, 8'd1);
        check("ar_rel_cnt", irq_counter, 8'd0);
        wr(2'd0, 8'd4);
        wr(2'd1, 8'd0);
        pulse(1);
        pulse(4);
        check("ar_ev", irq_counter, 8'd4);

        // random traffic
        run = 0;
        p   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic       w;
            logic [1:0] s;
            logic [7:0] d;
            if (run == 0) begin
                p   = ~p;
                run = $urandom_range(1, 6);
            end
            run--;
            w = ($urandom_range(0, 9) == 0);
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                d = 8'($urandom_range(0, 3));
            else
                d = 8'($urandom);
            cyc(w, s, d, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
